// File: rtl/alu_exec_pkg.sv
// Shared constants for the execute stage: ALU opcodes and default widths.
// Latency: n/a (constants only).
// Backpressure: n/a.
package alu_exec_pkg;

  // ALU function select encodings; 3'b100..3'b111 are reserved and yield zero
  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  // Default datapath / program-counter geometry
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_PC_W    = 32;
  localparam int DEF_PC_STEP = 4;

endpackage

// File: rtl/alu_exec_stage_alu_core.sv
// ALU core: FORWARD/ADD/AND/OR on two operands plus a result-is-zero flag.
// Latency: combinational (ALU_DELAY_EN adds sim-only #1 logic / #2 add delays).
// Backpressure: none; output follows inputs.
module alu_core
  import alu_exec_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [2:0]        i_aluop,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zero
);

  logic [DATA_W-1:0] w_fwd;
  logic [DATA_W-1:0] w_add;
  logic [DATA_W-1:0] w_and;
  logic [DATA_W-1:0] w_or;
  logic [DATA_W-1:0] w_result;

  // Per-function results; the adder is modelled slower than the logic ops
`ifdef ALU_DELAY_EN
  assign #1 w_fwd = i_b;
  assign #2 w_add = i_a + i_b;
  assign #1 w_and = i_a & i_b;
  assign #1 w_or  = i_a | i_b;
`else
  assign w_fwd = i_b;
  assign w_add = i_a + i_b;
  assign w_and = i_a & i_b;
  assign w_or  = i_a | i_b;
`endif

  // Function select; reserved opcodes deliberately produce zero
  always_comb begin
    w_result = '0;
    case (i_aluop)
      ALU_FWD: w_result = w_fwd;
      ALU_ADD: w_result = w_add;
      ALU_AND: w_result = w_and;
      ALU_OR:  w_result = w_or;
      default: w_result = '0;
    endcase
  end

  assign o_result = w_result;
  assign o_zero   = (w_result == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: operand B select, ALU, writeback select, next-PC select and PC register.
// Latency: all outputs combinational except PC, which registers PCNEXT one cycle later.
// Backpressure: BUSYWAIT high freezes PC indefinitely. Optional macro: ALU_DELAY_EN.
module alu_exec_stage
  import alu_exec_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PC_W    = DEF_PC_W,
  parameter int PC_STEP = DEF_PC_STEP
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              BUSYWAIT,
  input  logic [DATA_W-1:0] REGOUT1,
  input  logic [DATA_W-1:0] REGOUT2,
  input  logic [DATA_W-1:0] IMMEDIATE,
  input  logic              NEGSELECT,
  input  logic              IMSELECT,
  input  logic [2:0]        ALUOP,
  input  logic              DATA_MEM_SELECT,
  input  logic [DATA_W-1:0] READDATA,
  input  logic              JUMPSELECT,
  input  logic              BEQSELECT,
  input  logic [7:0]        OFFSET,
  output logic [DATA_W-1:0] ALURESULT,
  output logic              ZERO,
  output logic [DATA_W-1:0] WRITEBACK,
  output logic [PC_W-1:0]   PCNEXT,
  output logic [PC_W-1:0]   PC
);

  logic [DATA_W-1:0] w_regout2_neg;
  logic [DATA_W-1:0] w_opb;
  logic [DATA_W-1:0] w_aluresult;
  logic              w_zero;
  logic [PC_W-1:0]   w_pcplus;
  logic [PC_W-1:0]   w_offset_ext;
  logic [PC_W-1:0]   w_target;
  logic              w_take;
  logic [PC_W-1:0]   r_pc;

  // Operand B: immediate wins over negation; negation is two's complement
  assign w_regout2_neg = ~REGOUT2 + 1'b1;
  assign w_opb = IMSELECT  ? IMMEDIATE     :
                 NEGSELECT ? w_regout2_neg : REGOUT2;

  alu_core #(
    .DATA_W (DATA_W)
  ) u_alu_core (
    .i_a      (REGOUT1),
    .i_b      (w_opb),
    .i_aluop  (ALUOP),
    .o_result (w_aluresult),
    .o_zero   (w_zero)
  );

  assign ALURESULT = w_aluresult;
  assign ZERO      = w_zero;
  assign WRITEBACK = DATA_MEM_SELECT ? READDATA : w_aluresult;

  // Offset is a signed word count: sign-extend then scale to bytes
  assign w_offset_ext = {{(PC_W-10){OFFSET[7]}}, OFFSET, 2'b00};
  assign w_pcplus     = r_pc + PC_W'(PC_STEP);
  assign w_target     = w_pcplus + w_offset_ext;
  // A jump is unconditional, so it overrides the branch condition
  assign w_take       = JUMPSELECT | (BEQSELECT & w_zero);
  assign PCNEXT       = w_take ? w_target : w_pcplus;
  assign PC           = r_pc;

  // PC register: async clear, advance only when memory is not stalling
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
`ifdef ALU_DELAY_EN
      r_pc <= #1 '0;
`else
      r_pc <= '0;
`endif
    end else if (!BUSYWAIT) begin
`ifdef ALU_DELAY_EN
      r_pc <= #1 PCNEXT;
`else
      r_pc <= PCNEXT;
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;
  import alu_exec_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        BUSYWAIT;
  logic [7:0]  REGOUT1, REGOUT2, IMMEDIATE, READDATA, OFFSET;
  logic        NEGSELECT, IMSELECT, DATA_MEM_SELECT, JUMPSELECT, BEQSELECT;
  logic [2:0]  ALUOP;
  logic [7:0]  ALURESULT, WRITEBACK;
  logic        ZERO;
  logic [31:0] PCNEXT, PC;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  alu_exec_stage dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .BUSYWAIT        (BUSYWAIT),
    .REGOUT1         (REGOUT1),
    .REGOUT2         (REGOUT2),
    .IMMEDIATE       (IMMEDIATE),
    .NEGSELECT       (NEGSELECT),
    .IMSELECT        (IMSELECT),
    .ALUOP           (ALUOP),
    .DATA_MEM_SELECT (DATA_MEM_SELECT),
    .READDATA        (READDATA),
    .JUMPSELECT      (JUMPSELECT),
    .BEQSELECT       (BEQSELECT),
    .OFFSET          (OFFSET),
    .ALURESULT       (ALURESULT),
    .ZERO            (ZERO),
    .WRITEBACK       (WRITEBACK),
    .PCNEXT          (PCNEXT),
    .PC              (PC)
  );

  always #5 CLK = ~CLK;

  task automatic expect_val(input string tag, input logic [31:0] val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic check(input logic [31:0] obs);
    logic [31:0] exp;
    string tag;
    n_total++;
    if (exp_q.size() == 0) begin
      $error("FAIL scoreboard_empty: observed %0h with nothing expected", obs);
    end else begin
      exp = exp_q.pop_front();
      tag = tag_q.pop_front();
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_alu(input logic [7:0] a, input logic [7:0] r2, input logic [7:0] imm,
                         input logic neg, input logic ims, input logic [2:0] op);
    REGOUT1 = a; REGOUT2 = r2; IMMEDIATE = imm;
    NEGSELECT = neg; IMSELECT = ims; ALUOP = op;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    RESET = 1'b0; BUSYWAIT = 1'b0;
    set_alu(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, ALU_FWD);
    DATA_MEM_SELECT = 1'b0; READDATA = 8'h00;
    JUMPSELECT = 1'b0; BEQSELECT = 1'b0; OFFSET = 8'h00;

    // Reset state
    @(negedge CLK);
    expect_val("reset_pc", 32'd0);
    expect_val("reset_pcnext", 32'd4);
    #1; check(PC); check(PCNEXT);

    // Release and count 4, 8
    @(negedge CLK); RESET = 1'b1;
    @(posedge CLK); #1; expect_val("seq_pc4", 32'd4); check(PC);
    @(posedge CLK); #1; expect_val("seq_pc8", 32'd8); check(PC);

    // Async reset mid-cycle: PC clears without a clock edge
    @(negedge CLK); #2 RESET = 1'b0;
    #1; expect_val("async_reset_pc", 32'd0); check(PC);
    @(negedge CLK); RESET = 1'b1;
    @(posedge CLK); #1; expect_val("rel_pc4", 32'd4); check(PC);
    @(posedge CLK); #1; expect_val("rel_pc0_8", 32'd8); check(PC);

    // Hold PC at 8 for the combinational tests
    @(negedge CLK); BUSYWAIT = 1'b1;

    set_alu(8'd5, 8'd3, 8'h00, 1'b0, 1'b0, ALU_ADD);
    expect_val("add_res", 32'd8); expect_val("add_zero", 32'd0);
    #1; check(ALURESULT); check(ZERO);

    set_alu(8'd7, 8'd7, 8'h00, 1'b1, 1'b0, ALU_ADD);
    expect_val("neg_add_res", 32'd0); expect_val("neg_add_zero", 32'd1);
    #1; check(ALURESULT); check(ZERO);

    set_alu(8'hF0, 8'h3C, 8'h00, 1'b0, 1'b0, ALU_AND);
    expect_val("and_res", 32'h30); #1; check(ALURESULT);
    ALUOP = ALU_OR;
    expect_val("or_res", 32'hFC); expect_val("or_zero", 32'd0);
    #1; check(ALURESULT); check(ZERO);

    set_alu(8'h55, 8'h77, 8'h2A, 1'b0, 1'b1, ALU_FWD);
    expect_val("fwd_imm", 32'h2A); #1; check(ALURESULT);

    set_alu(8'd5, 8'd3, 8'h00, 1'b0, 1'b0, 3'b111);
    expect_val("rsv_res", 32'h00); expect_val("rsv_zero", 32'd1);
    #1; check(ALURESULT); check(ZERO);

    set_alu(8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, ALU_ADD);
    expect_val("ovf_res", 32'h00); expect_val("ovf_zero", 32'd1);
    #1; check(ALURESULT); check(ZERO);

    set_alu(8'h01, 8'h09, 8'h05, 1'b1, 1'b1, ALU_ADD);
    expect_val("imm_priority", 32'h06); #1; check(ALURESULT);

    // Next-PC selection with PC=8
    expect_val("pc_held8", 32'd8); #1; check(PC);
    set_alu(8'd5, 8'd3, 8'h00, 1'b0, 1'b0, ALU_ADD);
    JUMPSELECT = 1'b1; OFFSET = 8'h02;
    expect_val("jump_fwd", 32'd20); #1; check(PCNEXT);
    OFFSET = 8'hFE;
    expect_val("jump_back", 32'd4); #1; check(PCNEXT);
    JUMPSELECT = 1'b0; BEQSELECT = 1'b1; OFFSET = 8'h01;
    expect_val("beq_not_taken", 32'd12); #1; check(PCNEXT);
    set_alu(8'd7, 8'd7, 8'h00, 1'b1, 1'b0, ALU_ADD);
    expect_val("beq_taken", 32'd16); #1; check(PCNEXT);
    set_alu(8'd5, 8'd3, 8'h00, 1'b0, 1'b0, ALU_ADD);
    JUMPSELECT = 1'b1;
    expect_val("jump_and_beq", 32'd16); #1; check(PCNEXT);
    JUMPSELECT = 1'b0; BEQSELECT = 1'b0;

    // Writeback select
    set_alu(8'h11, 8'h00, 8'h00, 1'b0, 1'b0, ALU_ADD);
    READDATA = 8'h99; DATA_MEM_SELECT = 1'b0;
    expect_val("wb_alu", 32'h11); #1; check(WRITEBACK);
    DATA_MEM_SELECT = 1'b1;
    expect_val("wb_mem", 32'h99); #1; check(WRITEBACK);
    DATA_MEM_SELECT = 1'b0;

    // Advance to 12, then stall three edges
    @(negedge CLK); BUSYWAIT = 1'b0;
    @(posedge CLK); #1; expect_val("pc12", 32'd12); check(PC);
    @(negedge CLK); BUSYWAIT = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1; expect_val($sformatf("stall_hold_%0d", i), 32'd12); check(PC);
    end
    @(negedge CLK); BUSYWAIT = 1'b0;
    @(posedge CLK); #1; expect_val("stall_release", 32'd16); check(PC);

    // Reset released during a stall: PC stays 0 until BUSYWAIT drops
    @(negedge CLK); BUSYWAIT = 1'b1; RESET = 1'b0;
    #1; expect_val("stall_reset_pc", 32'd0); check(PC);
    @(negedge CLK); RESET = 1'b1;
    @(posedge CLK); #1; expect_val("stall_reset_hold", 32'd0); check(PC);
    @(negedge CLK); BUSYWAIT = 1'b0;
    @(posedge CLK); #1; expect_val("stall_reset_adv", 32'd4); check(PC);

    if (exp_q.size() != 0) begin
      n_total++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
